// File: rtl/stack_cpu_pkg.sv
// Shared types and instruction field positions for the stack CPU core.
package stack_cpu_pkg;

    localparam int OPC_MSB  = 7;
    localparam int OPC_LSB  = 5;
    localparam int ADDR_MSB = 4;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_NOT  = 3'b011,
        OP_PUSH = 3'b100,
        OP_POP  = 3'b101,
        OP_JMP  = 3'b110,
        OP_JZ   = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/operand_stack.sv
// Register-file operand stack; sp counts valid entries and indices wrap modulo DEPTH.
module operand_stack #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_replace_top,
    input  logic                     i_replace_next,
    input  logic [DATA_W-1:0]        i_data,
    output logic [DATA_W-1:0]        o_top,
    output logic [DATA_W-1:0]        o_next,
    output logic [$clog2(DEPTH):0]   o_sp
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic [IDX_W-1:0]  w_push_idx;
    logic [IDX_W-1:0]  w_top_idx;
    logic [IDX_W-1:0]  w_next_idx;

    // sp=0 reads land on the last entry because the index arithmetic wraps.
    assign w_push_idx = r_sp[IDX_W-1:0];
    assign w_top_idx  = w_push_idx - IDX_W'(1);
    assign w_next_idx = w_push_idx - IDX_W'(2);

    assign o_top  = r_mem[w_top_idx];
    assign o_next = r_mem[w_next_idx];
    assign o_sp   = r_sp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp <= '0;
            // NOTE: the stack array is reset explicitly so reads below sp are defined after reset.
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push)         r_mem[w_push_idx] <= i_data;
            if (i_replace_top)  r_mem[w_top_idx]  <= i_data;
            if (i_replace_next) r_mem[w_next_idx] <= i_data;
            if (i_push)         r_sp <= r_sp + SP_W'(1);
            else if (i_pop)     r_sp <= r_sp - SP_W'(1);
        end
    end

endmodule

// File: rtl/stack_cpu_core.sv
// Two-cycle FETCH/EXEC stack CPU driving a 32x8 unified memory.
// Define STACK_CHECK_EN to trap stack under/overflow into a HALT state.
module stack_cpu_core
    import stack_cpu_pkg::*;
#(
    parameter int STACK_DEPTH = 8,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [ADDR_W-1:0]             mem_address,
    output logic                          mem_write_enable,
    output logic [DATA_W-1:0]             mem_write_data,
    input  logic [DATA_W-1:0]             mem_read_data,
    output logic [ADDR_W-1:0]             pc,
    output logic [$clog2(STACK_DEPTH):0]  sp,
    output logic                          instr_done,
    output logic                          halted
);

    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    state_t             r_state;
    state_t             w_next_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [DATA_W-1:0]  r_ir;
    opcode_t            w_opcode;
    logic [ADDR_W-1:0]  w_target;
    logic [DATA_W-1:0]  w_top;
    logic [DATA_W-1:0]  w_next;
    logic [DATA_W-1:0]  w_alu;
    logic [SP_W-1:0]    w_sp;
    logic               w_push;
    logic               w_pop;
    logic               w_replace_top;
    logic               w_replace_next;
    logic               w_pc_load;
    logic               w_we;
    logic               w_err;

    assign w_opcode = opcode_t'(r_ir[OPC_MSB:OPC_LSB]);
    assign w_target = r_ir[ADDR_MSB:0];

    operand_stack #(.DEPTH(STACK_DEPTH), .DATA_W(DATA_W)) u_stack (
        .clk            (clk),
        .rst            (rst),
        .i_push         (w_push),
        .i_pop          (w_pop),
        .i_replace_top  (w_replace_top),
        .i_replace_next (w_replace_next),
        .i_data         (w_alu),
        .o_top          (w_top),
        .o_next         (w_next),
        .o_sp           (w_sp)
    );

`ifdef STACK_CHECK_EN
    always_comb begin
        w_err = 1'b0;
        if (r_state == S_EXEC) begin
            unique case (w_opcode)
                OP_ADD, OP_SUB, OP_AND: w_err = (w_sp < SP_W'(2));
                OP_NOT, OP_POP, OP_JZ:  w_err = (w_sp == '0);
                OP_PUSH:                w_err = (w_sp == SP_W'(STACK_DEPTH));
                default:                w_err = 1'b0;
            endcase
        end
    end
    assign halted = (r_state == S_HALT);
`else
    assign w_err  = 1'b0;
    assign halted = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next_state   = r_state;
        mem_address    = r_pc;
        w_we           = 1'b0;
        instr_done     = 1'b0;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        w_replace_top  = 1'b0;
        w_replace_next = 1'b0;
        w_pc_load      = 1'b0;
        w_alu          = w_top;
        unique case (r_state)
            S_FETCH: w_next_state = S_EXEC;
            S_EXEC: begin
                instr_done = 1'b1;
                if (w_opcode == OP_PUSH || w_opcode == OP_POP) mem_address = w_target;
                if (w_err) begin
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_FETCH;
                    unique case (w_opcode)
                        OP_ADD:  begin w_alu = w_next + w_top; w_replace_next = 1'b1; w_pop = 1'b1; end
                        OP_SUB:  begin w_alu = w_next - w_top; w_replace_next = 1'b1; w_pop = 1'b1; end
                        OP_AND:  begin w_alu = w_next & w_top; w_replace_next = 1'b1; w_pop = 1'b1; end
                        OP_NOT:  begin w_alu = ~w_top; w_replace_top = 1'b1; end
                        OP_PUSH: begin w_alu = mem_read_data; w_push = 1'b1; end
                        OP_POP:  begin w_we = 1'b1; w_pop = 1'b1; end
                        OP_JMP:  w_pc_load = 1'b1;
                        OP_JZ:   w_pc_load = (w_top == '0);
                        default: ;
                    endcase
                end
            end
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_FETCH;
        endcase
    end

    // Reset must suppress the negedge write of a pop that is being aborted.
    assign mem_write_enable = w_we & ~rst;
    assign mem_write_data   = w_top;
    assign pc               = r_pc;
    assign sp               = w_sp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_FETCH) begin
                r_ir <= mem_read_data;
                r_pc <= r_pc + ADDR_W'(1);
            end else if (w_pc_load) begin
                r_pc <= w_target;
            end
        end
    end

endmodule

// File: tb/tb_stack_cpu_core.sv
// Scoreboard bench for stack_cpu_core: an ISA model queues per-instruction expectations.
module tb_stack_cpu_core;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] mem_address;
    logic       mem_write_enable;
    logic [7:0] mem_write_data;
    logic [7:0] mem_read_data;
    logic [4:0] pc;
    logic [3:0] sp;
    logic       instr_done;
    logic       halted;

    logic [7:0] mem [32];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [4:0] pc;
        logic [3:0] sp;
        logic [7:0] top;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] m_mem [32];
    logic [7:0] m_stk [8];
    logic [4:0] m_pc;
    logic [3:0] m_sp;

    stack_cpu_core dut (
        .clk              (clk),
        .rst              (rst),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .pc               (pc),
        .sp               (sp),
        .instr_done       (instr_done),
        .halted           (halted)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address];
    always @(negedge clk) if (mem_write_enable) mem[mem_address] <= mem_write_data;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One instruction of the reference ISA; queues what the DUT must show.
    task automatic model_step();
        logic [7:0] ir, t, n;
        logic [2:0] ti, ni;
        exp_t       e;
        ir   = m_mem[m_pc];
        m_pc = m_pc + 5'd1;
        ti   = 3'(m_sp - 4'd1);
        ni   = 3'(m_sp - 4'd2);
        t    = m_stk[ti];
        n    = m_stk[ni];
        e.we = 1'b0; e.addr = m_pc; e.wdata = t;
        case (ir[7:5])
            3'd0: begin m_stk[ni] = n + t; m_sp = m_sp - 4'd1; end
            3'd1: begin m_stk[ni] = n - t; m_sp = m_sp - 4'd1; end
            3'd2: begin m_stk[ni] = n & t; m_sp = m_sp - 4'd1; end
            3'd3: m_stk[ti] = ~t;
            3'd4: begin e.addr = ir[4:0]; m_stk[m_sp[2:0]] = m_mem[ir[4:0]]; m_sp = m_sp + 4'd1; end
            3'd5: begin e.we = 1'b1; e.addr = ir[4:0]; m_mem[ir[4:0]] = t; m_sp = m_sp - 4'd1; end
            3'd6: m_pc = ir[4:0];
            default: if (t == 8'd0) m_pc = ir[4:0];
        endcase
        e.pc = m_pc; e.sp = m_sp; e.top = m_stk[3'(m_sp - 4'd1)];
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!instr_done && n < 8);
        check(tag, n, 1);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[0]  = 8'h9D; mem[1]  = 8'h9D; mem[2]  = 8'h00; mem[3]  = 8'hC7;
        mem[7]  = 8'hEC; mem[8]  = 8'h9C; mem[9]  = 8'h20; mem[10] = 8'hEF;
        mem[15] = 8'h9B; mem[16] = 8'h9A; mem[17] = 8'h40; mem[18] = 8'h60;
        mem[19] = 8'hBF; mem[20] = 8'hBE; mem[21] = 8'h9D; mem[22] = 8'hB9;
        mem[25] = 8'h55; mem[26] = 8'h66; mem[27] = 8'hAA; mem[28] = 8'h10;
        mem[29] = 8'h08; mem[30] = 8'h77;
        for (int i = 0; i < 32; i++) m_mem[i] = mem[i];
        for (int i = 0; i < 8; i++) m_stk[i] = 8'h00;
        m_pc = '0; m_sp = '0;
        for (int i = 0; i < 15; i++) model_step();

        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, 0);
        check("rst_sp", sp, 0);
        check("rst_addr", mem_address, 0);
        check("rst_we", mem_write_enable, 0);
        check("rst_done", instr_done, 0);
        check("rst_halted", halted, 0);
        @(negedge clk); rst = 1'b0;

        for (int k = 0; k < 15; k++) begin
            wait_done($sformatf("lat%0d", k));
            e = sb.pop_front();
            check($sformatf("we%0d", k), mem_write_enable, e.we);
            check($sformatf("addr%0d", k), mem_address, e.addr);
            if (e.we) check($sformatf("wdata%0d", k), mem_write_data, e.wdata);
            @(posedge clk); #1;
            check($sformatf("pc%0d", k), pc, e.pc);
            check($sformatf("sp%0d", k), sp, e.sp);
            check($sformatf("top%0d", k), mem_write_data, e.top);
            check($sformatf("done_low%0d", k), instr_done, 0);
            if (e.we) check($sformatf("mem%0d", k), mem[e.addr], e.wdata);
            case (k)
                2: begin
                    check("tp_cyc6", cyc, 6);
                    check("tp_pc3", pc, 3);
                    check("tp_sp1", sp, 1);
                    check("tp_top16", mem_write_data, 8'd16);
                end
                4: begin check("tp_jz_nobr_pc", pc, 8); check("tp_jz_nobr_sp", sp, 1); end
                7: begin
                    check("tp_jz_br_pc", pc, 15);
                    check("tp_jz_br_top", mem_write_data, 8'h00);
                    check("tp_jz_br_sp", sp, 1);
                end
                11: check("tp_not_top", mem_write_data, 8'hDD);
                12: check("tp_mem31", mem[31], 8'hDD);
                13: begin check("tp_mem30", mem[30], 8'h00); check("tp_sp0", sp, 0); end
                default: ;
            endcase
        end

        // Abort the pop at address 22 with reset raised during its EXEC cycle.
        wait_done("lat_rstpop");
        check("rstpop_we_pre", mem_write_enable, 1);
        check("rstpop_addr", mem_address, 25);
        rst = 1'b1;
        #1;
        check("rstpop_we_gated", mem_write_enable, 0);
        @(posedge clk); #1;
        check("rstpop_mem25", mem[25], 8'h55);
        check("rstpop_pc", pc, 0);
        check("rstpop_sp", sp, 0);
        check("rstpop_addr0", mem_address, 0);
        check("rstpop_done", instr_done, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("rstpop_exec", instr_done, 1);

`ifdef STACK_CHECK_EN
        // Add with a single entry must halt without touching the stack.
        mem[0] = 8'h9D; mem[1] = 8'h00; mem[29] = 8'h08;
        do_reset();
        wait_done("h_lat0");
        @(posedge clk); #1;
        wait_done("h_lat1");
        @(posedge clk); #1;
        check("h_add_halted", halted, 1);
        check("h_add_sp", sp, 1);
        check("h_add_top", mem_write_data, 8'h08);
        check("h_add_pc", pc, 2);
        repeat (3) @(posedge clk);
        #1;
        check("h_add_hold_pc", pc, 2);
        check("h_add_hold_done", instr_done, 0);
        check("h_add_hold_we", mem_write_enable, 0);

        // Ninth push into an 8-deep stack must halt with sp left at 8.
        for (int i = 0; i < 9; i++) mem[i] = 8'h9D;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wait_done($sformatf("h_push_lat%0d", i));
            @(posedge clk); #1;
        end
        check("h_push_halted", halted, 1);
        check("h_push_sp", sp, 8);
        check("h_push_pc", pc, 9);
`else
        check("no_halt", halted, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
